// File: rtl/ring_pkg.sv
// Shared definitions for the ring token arbiter: FSM state encoding and a one-hot decoder.
package ring_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } state_e;

    // Widest requester vector onehot2bin accepts; callers zero-extend to this width.
    localparam int unsigned MaxReq = 64;

    function automatic int unsigned onehot2bin(input logic [MaxReq-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_onehot_pick.sv
// Combinational round-robin pick: first set request at or above the one-hot token, wrapping.
module rr_onehot_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] ptr_i,
    output logic [N-1:0] pick_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] iso;

    always_comb begin
        // Low half keeps only requests at or above the token; high half is the wrapped copy.
        dbl    = {req_i, req_i & ~(ptr_i - N'(1))};
        iso    = dbl & (~dbl + (2*N)'(1));
        pick_o = iso[N-1:0] | iso[2*N-1:N];
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a rotating one-hot token, hold timeout and one-cycle turnaround gap.
module ring_token_arbiter
    import ring_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned IDX_W    = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             sys_rst_n,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     done_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             timeout_o,
    output logic             busy_o
);

    localparam int unsigned HoldW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);
    localparam logic [HoldW-1:0] HoldMax  = {HoldW{1'b1}};

    state_e         state_q, state_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic           timeout_q, timeout_d;

    logic [N-1:0]   pick;
    logic           own_done;
    logic           own_req;
    logic           hold_expired;
    logic [MaxReq-1:0] gnt_ext;

    rr_onehot_pick #(
        .N (N)
    ) u_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .pick_o (pick)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        hold_d       = hold_q;
        timeout_d    = 1'b0;
        own_done     = |(done_i & gnt_q);
        own_req      = |(req_i & gnt_q);
        hold_expired = (MAX_HOLD != 0) && (hold_q == HoldLast);

        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    gnt_d   = pick;
                    hold_d  = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (own_done || !own_req || hold_expired) begin
                    gnt_d     = '0;
                    ptr_d     = {gnt_q[N-2:0], gnt_q[N-1]};
                    state_d   = StGap;
                    // A done arriving on the last allowed cycle is a normal release.
                    timeout_d = hold_expired && !own_done;
                end else if (hold_q != HoldMax) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= N'(1);
            gnt_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        gnt_ext         = '0;
        gnt_ext[N-1:0]  = gnt_q;
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = |gnt_q;
    assign gnt_idx_o   = IDX_W'(onehot2bin(gnt_ext));
    assign timeout_o   = timeout_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Scoreboard bench for ring_token_arbiter: directed stimulus queues expected grants, a monitor checks them.
module tb_ring_token_arbiter;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        int         len;
        logic       to;
        logic       busy_after;
    } exp_t;

    logic       clk;
    logic       sys_rst_n;
    logic [7:0] req_i;
    logic [7:0] done_i;
    logic [7:0] gnt_o;
    logic       gnt_valid_o;
    logic [2:0] gnt_idx_o;
    logic       timeout_o;
    logic       busy_o;

    int   checks;
    int   failures;
    exp_t exp_q[$];

    ring_token_arbiter #(
        .N        (8),
        .MAX_HOLD (4),
        .IDX_W    (3)
    ) dut (
        .clk_i       (clk),
        .sys_rst_n   (sys_rst_n),
        .req_i       (req_i),
        .done_i      (done_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_idx_o   (gnt_idx_o),
        .timeout_o   (timeout_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input logic [7:0] g, input logic [2:0] i, input int len,
                                input logic to, input logic busy_after);
        exp_t e;
        e.gnt = g;
        e.idx = i;
        e.len = len;
        e.to = to;
        e.busy_after = busy_after;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!gnt_valid_o && n < 20) begin
            tick();
            n++;
        end
        check({name, " grant wait"}, {31'd0, gnt_valid_o}, 32'd1);
    endtask

    task automatic wait_drop(input string name);
        int n;
        n = 0;
        while (gnt_valid_o && n < 20) begin
            tick();
            n++;
        end
        check({name, " release wait"}, {31'd0, gnt_valid_o}, 32'd0);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req_i = '0;
        done_i = '0;
        tick();
        tick();
        sys_rst_n = 1'b1;
    endtask

    function automatic logic [2:0] ref_idx(input logic [7:0] g);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Monitor: grant starts pop the scoreboard; each grant end checks length, timeout and gap.
    initial begin
        exp_t cur;
        logic in_grant;
        int   len;
        in_grant = 1'b0;
        len = 0;
        cur = '{gnt: '0, idx: '0, len: 0, to: 1'b0, busy_after: 1'b0};
        forever begin
            @(negedge clk);
            check("valid_vs_gnt", {31'd0, gnt_valid_o}, {31'd0, |gnt_o});
            check("gnt_onehot0", {31'd0, $onehot0(gnt_o)}, 32'd1);
            check("idx_vs_gnt", {29'd0, gnt_idx_o}, {29'd0, ref_idx(gnt_o)});
            if (!in_grant && gnt_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", {24'd0, gnt_o}, 32'd0);
                    cur = '{gnt: gnt_o, idx: gnt_idx_o, len: 0, to: 1'b0, busy_after: 1'b1};
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_vec", {24'd0, gnt_o}, {24'd0, cur.gnt});
                    check("grant_idx", {29'd0, gnt_idx_o}, {29'd0, cur.idx});
                end
                check("busy_in_grant", {31'd0, busy_o}, 32'd1);
                in_grant = 1'b1;
                len = 1;
            end else if (in_grant && gnt_valid_o) begin
                len++;
                check("grant_stable", {24'd0, gnt_o}, {24'd0, cur.gnt});
                check("timeout_during_grant", {31'd0, timeout_o}, 32'd0);
            end else if (in_grant && !gnt_valid_o) begin
                check("grant_len", len, cur.len);
                check("timeout_after", {31'd0, timeout_o}, {31'd0, cur.to});
                check("busy_after", {31'd0, busy_o}, {31'd0, cur.busy_after});
                in_grant = 1'b0;
            end else begin
                check("timeout_idle", {31'd0, timeout_o}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        sys_rst_n = 1'b0;
        req_i = '0;
        done_i = '0;
        tick();
        tick();
        check("rst_gnt", {24'd0, gnt_o}, 32'd0);
        check("rst_valid", {31'd0, gnt_valid_o}, 32'd0);
        check("rst_idx", {29'd0, gnt_idx_o}, 32'd0);
        check("rst_timeout", {31'd0, timeout_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        sys_rst_n = 1'b1;

        // Single requester, released by done after one cycle.
        expect_grant(8'h04, 3'd2, 1, 1'b0, 1'b1);
        req_i = 8'h04;
        tick();
        check("t1_gnt", {24'd0, gnt_o}, 32'h04);
        check("t1_idx", {29'd0, gnt_idx_o}, 32'd2);
        done_i = 8'h04;
        tick();
        done_i = '0;
        req_i = '0;
        check("t1_gap_gnt", {24'd0, gnt_o}, 32'd0);
        check("t1_gap_busy", {31'd0, busy_o}, 32'd1);
        do_reset();

        // All requesting: full rotation with wrap back to 0.
        for (int k = 0; k < 9; k++) begin
            expect_grant(8'(1 << (k % 8)), 3'(k % 8), 2, 1'b0, 1'b1);
        end
        req_i = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_valid("t2");
            tick();
            done_i = 8'hFF;
            tick();
            done_i = '0;
        end
        req_i = '0;
        do_reset();

        // Hold timeout, then re-grant to the same requester.
        expect_grant(8'h01, 3'd0, 4, 1'b1, 1'b1);
        expect_grant(8'h01, 3'd0, 1, 1'b0, 1'b1);
        req_i = 8'h01;
        wait_valid("t3a");
        wait_drop("t3");
        wait_valid("t3b");
        done_i = 8'h01;
        req_i = '0;
        tick();
        done_i = '0;
        do_reset();

        // Foreign done bits ignored; own done on the last allowed cycle is a normal release.
        expect_grant(8'h08, 3'd3, 4, 1'b0, 1'b1);
        req_i = 8'h08;
        wait_valid("t4");
        done_i = 8'h22;
        tick();
        tick();
        tick();
        check("t4_held", {24'd0, gnt_o}, 32'h08);
        done_i = 8'h08;
        tick();
        done_i = '0;
        req_i = '0;
        do_reset();

        // Request drop releases; token moves past owner 5 to 6 before wrapping to 0.
        expect_grant(8'h20, 3'd5, 1, 1'b0, 1'b1);
        expect_grant(8'h40, 3'd6, 1, 1'b0, 1'b1);
        req_i = 8'h20;
        wait_valid("t5a");
        req_i = 8'h41;
        tick();
        wait_valid("t5b");
        done_i = 8'hFF;
        req_i = '0;
        tick();
        done_i = '0;
        do_reset();

        // Reset mid-grant drops everything; token returns to bit 0.
        expect_grant(8'h10, 3'd4, 1, 1'b0, 1'b0);
        expect_grant(8'h01, 3'd0, 1, 1'b0, 1'b1);
        req_i = 8'h10;
        wait_valid("t6a");
        sys_rst_n = 1'b0;
        tick();
        check("t6_rst_gnt", {24'd0, gnt_o}, 32'd0);
        check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
        check("t6_rst_timeout", {31'd0, timeout_o}, 32'd0);
        sys_rst_n = 1'b1;
        req_i = 8'h81;
        wait_valid("t6b");
        done_i = 8'hFF;
        req_i = '0;
        tick();
        done_i = '0;

        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
